// File: rtl/serializer_piso.sv
// serializer_piso: parallel-in / serial-out lane serializer with a one-word
// holding buffer so that back-to-back words stream without idle beats.
// Each DIN_WIDTH-bit word is emitted as DIN_WIDTH/LANE_WIDTH lanes, either
// least significant lane first (MSB_FIRST=0) or most significant first.
module serializer_piso #(
  parameter int DIN_WIDTH  = 16,
  parameter int LANE_WIDTH = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DIN_WIDTH-1:0]  iv_din,
  input  logic                  i_din_valid,
  output logic                  o_din_ready,
  output logic [LANE_WIDTH-1:0] ov_dout,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready,
  output logic                  o_last,
  output logic                  o_busy
);

  // Number of lanes per word; guarded so a zero lane width cannot divide by zero
  localparam int N  = (LANE_WIDTH > 0) ? (DIN_WIDTH / LANE_WIDTH) : 0;
  localparam int CW = (N >= 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if ((LANE_WIDTH < 1) || ((DIN_WIDTH % LANE_WIDTH) != 0) || (N < 2)) begin : g_bad_params
    $error("serializer_piso: LANE_WIDTH must divide DIN_WIDTH with at least 2 lanes");
  end

  // EMPTY: nothing stored; ACTIVE: shift_reg only; FULL: shift_reg and hold_reg
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DIN_WIDTH-1:0]   shift_q, shift_d;
  logic [DIN_WIDTH-1:0]   hold_q,  hold_d;
  logic [CW-1:0]          cnt_q,   cnt_d;

  logic [DIN_WIDTH-1:0]   shifted_s;
  logic [LANE_WIDTH-1:0]  lane_s;
  logic                   din_ready_s;
  logic                   dout_valid_s;
  logic                   acc_s;
  logic                   xfer_s;
  logic                   last_beat_s;
  logic                   last_xfer_s;

  // Handshake qualifiers; both sides are blocked while disabled or in reset
  assign din_ready_s  = i_en & ~i_rst & (state_q != ST_FULL);
  assign dout_valid_s = i_en & ~i_rst & (state_q != ST_EMPTY);
  assign acc_s        = i_en & i_din_valid & din_ready_s;
  assign xfer_s       = i_en & dout_valid_s & i_dout_ready;
  assign last_beat_s  = (cnt_q == LAST_CNT);
  assign last_xfer_s  = xfer_s & last_beat_s;

  assign o_din_ready  = din_ready_s;
  assign o_dout_valid = dout_valid_s;
  assign o_last       = dout_valid_s & last_beat_s;
  assign o_busy       = (state_q != ST_EMPTY);
  assign ov_dout      = (state_q != ST_EMPTY) ? lane_s : {LANE_WIDTH{1'b0}};

  // Pick the outgoing lane and the zero-filled shift for the configured order
  always_comb begin
    lane_s    = shift_q[LANE_WIDTH-1:0];
    shifted_s = shift_q >> LANE_WIDTH;
    if (MSB_FIRST != 0) begin
      lane_s    = shift_q[DIN_WIDTH-1 -: LANE_WIDTH];
      shifted_s = shift_q << LANE_WIDTH;
    end else begin
      lane_s    = shift_q[LANE_WIDTH-1:0];
      shifted_s = shift_q >> LANE_WIDTH;
    end
  end

  // Next-state and storage update for the shift/hold pair
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;

    // A non-final beat leaving the block advances the current word by one lane
    if (xfer_s && !last_beat_s) begin
      shift_d = shifted_s;
      cnt_d   = cnt_q + CW'(1'b1);
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end

    case (state_q)
      ST_EMPTY: begin
        if (acc_s) begin
          shift_d = iv_din;
          cnt_d   = {CW{1'b0}};
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ACTIVE: begin
        if (acc_s) begin
          if (last_xfer_s) begin
            // Word boundary coincides with a new word: load straight in, no bubble
            shift_d = iv_din;
            cnt_d   = {CW{1'b0}};
            state_d = ST_ACTIVE;
          end else begin
            hold_d  = iv_din;
            state_d = ST_FULL;
          end
        end else if (last_xfer_s) begin
          shift_d = {DIN_WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_FULL: begin
        if (last_xfer_s) begin
          shift_d = hold_q;
          hold_d  = {DIN_WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        // Unreachable encoding: drop everything and return to a known idle state
        shift_d = {DIN_WIDTH{1'b0}};
        hold_d  = {DIN_WIDTH{1'b0}};
        cnt_d   = {CW{1'b0}};
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and storage registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      shift_q <= {DIN_WIDTH{1'b0}};
      hold_q  <= {DIN_WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serializer_piso.sv
// Bench for serializer_piso: two instances (LSB-first and MSB-first) share the
// same stimulus; a queue-based model predicts every output each cycle, and
// directed sequences pin exact beat orders with literal expectations.
module tb_serializer_piso;

  localparam int DW = 16;
  localparam int LW = 4;
  localparam int N  = DW / LW;

  logic          i_clk;
  logic          i_rst;
  logic          i_en;
  logic [DW-1:0] iv_din;
  logic          i_din_valid;
  logic          i_dout_ready;

  logic          l_rdy, l_vld, l_last, l_busy;
  logic [LW-1:0] l_dout;
  logic          m_rdy, m_vld, m_last, m_busy;
  logic [LW-1:0] m_dout;

  int n_cmp = 0;
  int n_err = 0;

  serializer_piso #(.DIN_WIDTH(DW), .LANE_WIDTH(LW), .MSB_FIRST(0)) u_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .iv_din(iv_din),
    .i_din_valid(i_din_valid), .o_din_ready(l_rdy), .ov_dout(l_dout),
    .o_dout_valid(l_vld), .i_dout_ready(i_dout_ready), .o_last(l_last),
    .o_busy(l_busy));

  serializer_piso #(.DIN_WIDTH(DW), .LANE_WIDTH(LW), .MSB_FIRST(1)) u_msb (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .iv_din(iv_din),
    .i_din_valid(i_din_valid), .o_din_ready(m_rdy), .ov_dout(m_dout),
    .o_dout_valid(m_vld), .i_dout_ready(i_dout_ready), .o_last(m_last),
    .o_busy(m_busy));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Words resident in the block, oldest first, and lanes already sent of the oldest.
  logic [DW-1:0] mq[$];
  int            m_idx = 0;
  bit            m_acc, m_xfer;

  function automatic logic [LW-1:0] lane_of(input logic [DW-1:0] w, input int pos);
    logic [DW-1:0] t;
    t = w >> (LW * pos);
    return t[LW-1:0];
  endfunction

  function automatic logic exp_rdy();
    return i_en & ~i_rst & (mq.size() < 2);
  endfunction
  function automatic logic exp_vld();
    return i_en & ~i_rst & (mq.size() > 0);
  endfunction
  function automatic logic exp_last();
    return exp_vld() & (m_idx == N - 1);
  endfunction
  function automatic logic [LW-1:0] exp_dout(input bit msb_first);
    if (mq.size() == 0) return '0;
    return msb_first ? lane_of(mq[0], N - 1 - m_idx) : lane_of(mq[0], m_idx);
  endfunction

  // Model advance: count beats of the oldest word, retire it after N, append accepted words
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mq.delete();
      m_idx = 0;
    end else begin
      m_acc  = i_en & i_din_valid & (mq.size() < 2);
      m_xfer = i_en & i_dout_ready & (mq.size() > 0);
      if (m_xfer) begin
        m_idx++;
        if (m_idx == N) begin
          void'(mq.pop_front());
          m_idx = 0;
        end
      end
      if (m_acc) mq.push_back(iv_din);
    end
  end

  // Per-cycle compare of both instances against the model, plus beat capture
  logic [LW-1:0] lsb_beats[$];
  logic [LW-1:0] msb_beats[$];

  always @(negedge i_clk) begin
    chk("lsb_ready", l_rdy,  exp_rdy());
    chk("lsb_valid", l_vld,  exp_vld());
    chk("lsb_last",  l_last, exp_last());
    chk("lsb_busy",  l_busy, mq.size() > 0);
    chk("lsb_dout",  l_dout, exp_dout(1'b0));
    chk("msb_ready", m_rdy,  exp_rdy());
    chk("msb_valid", m_vld,  exp_vld());
    chk("msb_last",  m_last, exp_last());
    chk("msb_busy",  m_busy, mq.size() > 0);
    chk("msb_dout",  m_dout, exp_dout(1'b1));
    if (l_vld && i_dout_ready) lsb_beats.push_back(l_dout);
    if (m_vld && i_dout_ready) msb_beats.push_back(m_dout);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    bit done;
    done = 1'b0;
    iv_din      = w;
    i_din_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge i_clk);
      done = l_rdy;
      step();
    end
    i_din_valid = 1'b0;
    if (!done) fail_now("send_word");
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge i_clk);
      idle = ~l_busy & ~m_busy;
      step();
    end
    if (!idle) fail_now("wait_idle");
  endtask

  task automatic chk_beats(input string name, input logic [LW-1:0] got[$],
                           input logic [LW-1:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_beat%0d", name, i), got[i], exp[i]);
    end
  endtask

  task automatic clear_beats();
    lsb_beats.delete();
    msb_beats.delete();
  endtask

  // ---------------- main sequence ----------------
  logic [LW-1:0] exp_l[$];
  logic [LW-1:0] exp_m[$];

  initial begin
    i_rst        = 1'b1;
    i_en         = 1'b1;
    iv_din       = '0;
    i_din_valid  = 1'b0;
    i_dout_ready = 1'b0;

    // Reset state
    @(negedge i_clk);
    chk("rst_ready", l_rdy, 1'b0);
    chk("rst_valid", l_vld, 1'b0);
    chk("rst_last",  l_last, 1'b0);
    chk("rst_busy",  l_busy, 1'b0);
    chk("rst_dout",  l_dout, 4'h0);
    step();
    i_rst = 1'b0;
    step();

    // Order check, both lane orders
    clear_beats();
    i_dout_ready = 1'b1;
    send_word(16'hA5C3);
    wait_idle();
    exp_l = '{4'h3, 4'hC, 4'h5, 4'hA};
    exp_m = '{4'hA, 4'h5, 4'hC, 4'h3};
    chk_beats("order_lsb", lsb_beats, exp_l);
    chk_beats("order_msb", msb_beats, exp_m);
    chk("order_idle_dout", l_dout, 4'h0);

    // Streaming two words back to back
    clear_beats();
    send_word(16'h1234);
    send_word(16'h5678);
    @(negedge i_clk);
    chk("stream_full_ready", l_rdy, 1'b0);
    step();
    wait_idle();
    exp_l = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
    exp_m = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    chk_beats("stream_lsb", lsb_beats, exp_l);
    chk_beats("stream_msb", msb_beats, exp_m);

    // Backpressure at beat 2
    clear_beats();
    i_dout_ready = 1'b0;
    send_word(16'h9E71);
    i_dout_ready = 1'b1;
    step();
    step();
    i_dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("bp_lsb_hold", l_dout, 4'hE);
      chk("bp_msb_hold", m_dout, 4'h7);
      chk("bp_last_low", l_last, 1'b0);
      step();
    end
    i_dout_ready = 1'b1;
    wait_idle();
    exp_l = '{4'h1, 4'h7, 4'hE, 4'h9};
    exp_m = '{4'h9, 4'hE, 4'h7, 4'h1};
    chk_beats("bp_lsb", lsb_beats, exp_l);
    chk_beats("bp_msb", msb_beats, exp_m);

    // Reset mid-word with a second word held
    send_word(16'h8421);
    send_word(16'hFFFF);
    step();
    step();
    i_rst = 1'b1;
    #1;
    chk("midrst_valid", l_vld, 1'b0);
    chk("midrst_ready", l_rdy, 1'b0);
    chk("midrst_busy",  l_busy, 1'b0);
    chk("midrst_dout",  l_dout, 4'h0);
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("postrst_ready", l_rdy, 1'b1);
    chk("postrst_valid", l_vld, 1'b0);
    step();
    clear_beats();
    send_word(16'h0F0F);
    wait_idle();
    exp_l = '{4'hF, 4'h0, 4'hF, 4'h0};
    exp_m = '{4'h0, 4'hF, 4'h0, 4'hF};
    chk_beats("postrst_lsb", lsb_beats, exp_l);
    chk_beats("postrst_msb", msb_beats, exp_m);

    // Enable freeze after the first beat
    clear_beats();
    send_word(16'h3C5A);
    step();
    i_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("frz_ready", l_rdy, 1'b0);
      chk("frz_valid", l_vld, 1'b0);
      chk("frz_busy",  l_busy, 1'b1);
      chk("frz_lsb_dout", l_dout, 4'h5);
      chk("frz_msb_dout", m_dout, 4'hC);
      step();
    end
    i_en = 1'b1;
    wait_idle();
    exp_l = '{4'hA, 4'h5, 4'hC, 4'h3};
    exp_m = '{4'h3, 4'hC, 4'h5, 4'hA};
    chk_beats("frz_lsb", lsb_beats, exp_l);
    chk_beats("frz_msb", msb_beats, exp_m);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_en         = ($urandom_range(0, 9) != 0);
      i_din_valid  = $urandom_range(0, 1);
      i_dout_ready = ($urandom_range(0, 3) != 0);
      iv_din       = DW'($urandom);
      i_rst        = ($urandom_range(0, 299) == 0);
      step();
    end
    i_rst       = 1'b0;
    i_en        = 1'b1;
    i_din_valid = 1'b0;
    i_dout_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer_piso.md
# serializer_piso

Parametrised parallel-in/serial-out serializer for the FIR filter datapath. It splits each DIN_WIDTH-bit word into DIN_WIDTH/LANE_WIDTH lanes and emits one lane per beat, either LSB-first or MSB-first. Both sides use a full valid/ready handshake. A one-word holding buffer lets the next word be accepted while the current one is still shifting, so back-to-back words stream with no idle beats. It sits between the word-parallel filter core and the narrow serial output link.

## Interface
- DIN_WIDTH, 16: input word width in bits.
- LANE_WIDTH, 1: output beat width. Must divide DIN_WIDTH, and N = DIN_WIDTH/LANE_WIDTH must be ≥ 2; otherwise elaboration fails with an error.
- MSB_FIRST, 0: 0 sends the least significant lane first; 1 sends the most significant lane first.
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  global enable. While low, all state is frozen and both handshakes are blocked.
- iv_din  in  DIN_WIDTH  input word.
- i_din_valid  in  1  input word valid.
- o_din_ready  out  1  block can accept a word.
- ov_dout  out  LANE_WIDTH  current output lane.
- o_dout_valid  out  1  ov_dout valid.
- i_dout_ready  in  1  downstream accepts a beat.
- o_last  out  1  current beat is the final lane of its word.
- o_busy  out  1  any word resident (shift or hold).

## Operation
- Storage:
  - shift_reg: DIN_WIDTH bits, the word currently being serialized.
  - hold_reg: DIN_WIDTH bits, the next queued word.
  - beat counter: clog2(N) bits, counts lanes sent from shift_reg.
- Input accept (acc) = i_en & i_din_valid & o_din_ready.
- Output transfer (xfer) = i_en & o_dout_valid & i_dout_ready.
- last_xfer = xfer & (counter == N-1).
- States:
  - EMPTY: nothing stored.
  - ACTIVE: shift_reg loaded, hold empty.
  - FULL: shift_reg and hold_reg both loaded.
- o_din_ready = i_en & ~i_rst & (state != FULL).
- o_dout_valid = i_en & ~i_rst & (state != EMPTY).
- o_busy = (state != EMPTY).
- o_last = o_dout_valid & (counter == N-1).
- Transitions:
  - EMPTY, acc → ACTIVE: iv_din loads directly into shift_reg, counter=0.
  - ACTIVE, acc & ~last_xfer → FULL: iv_din loads into hold_reg.
  - ACTIVE, acc & last_xfer → ACTIVE: iv_din loads directly into shift_reg, counter=0 (no bubble).
  - ACTIVE, last_xfer & ~acc → EMPTY: shift_reg cleared to 0, counter=0.
  - FULL, last_xfer → ACTIVE: hold_reg moves to shift_reg, counter=0. acc cannot occur in FULL because o_din_ready=0.
  - Any state, xfer that is not last: shift_reg shifts by LANE_WIDTH with zero fill, counter+1.
- Lane selection:
  - MSB_FIRST=0: ov_dout = shift_reg[LANE_WIDTH-1:0], shift right.
  - MSB_FIRST=1: ov_dout = shift_reg[DIN_WIDTH-1 -: LANE_WIDTH], shift left.
  - Bit order inside a lane is never reversed.
- ov_dout is 0 whenever the state is EMPTY.
- No invalid encodings are reachable. Any illegal state value recovers to EMPTY with storage cleared.

## Timing
- Reset (async assert; release synchronous to i_clk): state=EMPTY, counter=0, shift_reg=0, hold_reg=0. Outputs during reset: o_din_ready=0, o_dout_valid=0, o_last=0, o_busy=0, ov_dout=0.
- Reset mid-word: in-flight and held words are discarded immediately. The first cycle after release has o_din_ready=i_en and no stale beats.
- Latency: a word accepted on edge k presents its first lane on ov_dout after edge k, with o_dout_valid high in cycle k+1.
- Throughput: one word per N beats. With i_dout_ready held high and input always valid, o_dout_valid stays high continuously.
- Backpressure: while o_dout_valid=1 and i_dout_ready=0, ov_dout and o_last hold stable.
- i_en=0: no register changes. o_din_ready and o_dout_valid read 0, and resume their prior values when i_en returns.

## Test plan
- Order check. DIN=16, LANE=4, MSB_FIRST=0. Send 0xA5C3 with ready high → beats 0x3, 0xC, 0x5, 0xA on consecutive cycles; o_last only on 0xA; then o_busy=0 and ov_dout=0.
- Order check, MSB first. Same word with MSB_FIRST=1 → beats 0xA, 0x5, 0xC, 0x3.
- Streaming. Send 0x1234 then 0x5678 with valid held high → 8 contiguous valid beats 4,3,2,1,8,7,6,5; o_din_ready drops to 0 while FULL and rises on the cycle after the first word's last beat.
- Backpressure. Hold i_dout_ready low for 3 cycles at beat 2 → that beat's value stays stable; no beat is lost or duplicated; the total is exactly 4 beats.
- Reset mid-word. DIN=8, LANE=1. Send 0x81, assert i_rst after 3 beats → outputs drop immediately. Then send 0x0F → beats 1,1,1,1,0,0,0,0.
- Enable freeze. Pull i_en low for 5 cycles mid-word → counter, ov_dout and state are unchanged; handshakes read 0; the sequence completes correctly after i_en returns.
